// File: rtl/execute_hazard_ctrl.sv
// execute_hazard_ctrl: forwarding selects, stall/flush controls and multi-cycle
// multiply sequencing for the execute stage of the five-stage pipeline.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating stall/flush
// performance counters; when undefined StallCnt and FlushCnt read as zero.
module execute_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MulStartE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             BubbleM,
    output logic             MulBusy,
    output logic             MulDoneE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic [0:0] {StRun, StMul} state_e;

    // Remaining MUL-state cycles after the first; MUL_LAT <= 16 fits in 4 bits.
    localparam logic [3:0] CntInit     = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
    localparam bit         SingleCycle = (MUL_LAT == 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       run, mul_start, lw_stall;

    // Forwarding muxes: memory stage has priority over writeback, x0 never forwarded.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
    end

    // Stall, flush and multiply status outputs decoded from state and inputs.
    always_comb begin
        run       = (state_q == StRun);
        // A taken branch kills the multiply in the same slot.
        mul_start = run && MulStartE && !PCSrcE;
        lw_stall  = run && (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

        StallF   = lw_stall || !run;
        StallD   = lw_stall || !run;
        StallE   = !run && (cnt_q != 4'd0);
        BubbleM  = !run && (cnt_q != 4'd0);
        MulBusy  = !run;
        MulDoneE = (!run && (cnt_q == 4'd0)) || (mul_start && SingleCycle);
        FlushD   = run && PCSrcE;
        FlushE   = run && (PCSrcE || lw_stall);
    end

    // Next-state logic for the multiply sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (mul_start && !SingleCycle) begin
                    state_d = StMul;
                    cnt_d   = CntInit;
                end
            end
            StMul: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if ((FlushD || FlushE) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule
